// File: rtl/data_sram_arbiter.sv
// Two-port arbiter in front of a single-ported data SRAM: the data side has
// priority, and the instruction side is forced through after STARVE_MAX lost rounds.
module data_sram_arbiter #(
    parameter int RD_LAT     = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [3:0]  if_wen,
    input  logic [31:0] if_addr,
    input  logic [31:0] if_wdata,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    input  logic        mem_req,
    input  logic [3:0]  mem_wen,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic        mem_gnt,
    output logic        mem_rvalid,
    output logic [31:0] mem_rdata,
    output logic        sram_en,
    output logic [3:0]  sram_wen,
    output logic [31:0] sram_addr,
    output logic [31:0] sram_wdata,
    input  logic [31:0] sram_rdata,
    output logic        stallreq_if,
    output logic        stallreq_mem,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, RD_WAIT, RESP} state_t;

    localparam logic [1:0] LAT_LOAD   = (RD_LAT >= 2) ? 2'(RD_LAT - 2) : 2'd0;
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_t      state;
    logic        owner_mem;
    logic [1:0]  lat_cnt;
    logic [3:0]  starve_cnt;

    logic arb, starved, if_win, mem_win, win_read, in_resp;

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
        arb        = !rst && (state != RD_WAIT);
        starved    = (starve_cnt == STARVE_LIM);
        mem_win    = arb && mem_req && !(starved && if_req);
        if_win     = arb && if_req && !mem_win;
        win_read   = (mem_win && (mem_wen == 4'd0)) || (if_win && (if_wen == 4'd0));
        in_resp    = !rst && (state == RESP);

        sram_en    = 1'b0;
        sram_wen   = 4'd0;
        sram_addr  = 32'd0;
        sram_wdata = 32'd0;
        if (mem_win) begin
            sram_en    = 1'b1;
            sram_wen   = mem_wen;
            sram_addr  = mem_addr;
            sram_wdata = mem_wdata;
        end else if (if_win) begin
            sram_en    = 1'b1;
            sram_wen   = if_wen;
            sram_addr  = if_addr;
            sram_wdata = if_wdata;
        end
    end

    assign if_gnt       = if_win;
    assign mem_gnt      = mem_win;
    assign if_rvalid    = in_resp && !owner_mem;
    assign mem_rvalid   = in_resp && owner_mem;
    assign if_rdata     = if_rvalid  ? sram_rdata : 32'd0;
    assign mem_rdata    = mem_rvalid ? sram_rdata : 32'd0;
    assign busy         = !rst && (state == RD_WAIT);
    // The data side also holds while its own read is still in flight.
    assign stallreq_if  = !rst && if_req && !if_win;
    assign stallreq_mem = !rst && ((mem_req && !mem_win) || (busy && owner_mem));

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            owner_mem  <= 1'b0;
            lat_cnt    <= 2'd0;
            starve_cnt <= 4'd0;
        end else begin
            case (state)
                RD_WAIT: begin
                    if (lat_cnt == 2'd0) state <= RESP;
                    else                 lat_cnt <= lat_cnt - 2'd1;
                end
                default: begin
                    if (win_read) begin
                        owner_mem <= mem_win;
                        if (RD_LAT == 1) begin
                            state <= RESP;
                        end else begin
                            state   <= RD_WAIT;
                            lat_cnt <= LAT_LOAD;
                        end
                    end else begin
                        state <= IDLE;
                    end
                    // A pending IF request that did not win can only have lost to mem.
                    if (if_win || !if_req)  starve_cnt <= 4'd0;
                    else if (!starved)      starve_cnt <= starve_cnt + 4'd1;
                end
            endcase
        end
    end

endmodule
